// File: rtl/core_control_cycle_seq.sv
// Per-instruction cycle sequencer for the core control unit: walks each instruction
// through shift, multiply wait, multi-beat transfer, base writeback and exception cycles.
module core_control_cycle_seq #(
  parameter int XFER_W     = 5,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic              exception,
  input  logic              data_snd_shift_by_reg,
  input  logic              trivial_shift,
  input  logic              mul,
  input  logic              ldst,
  input  logic [XFER_W-1:0] xfer_count,
  input  logic              ldst_writeback,
  input  logic              mem_ready,
  input  logic              mem_error,
  output logic [2:0]        cycle,
  output logic [2:0]        next_cycle,
  output logic [XFER_W-1:0] xfer_idx,
  output logic              last_xfer,
  output logic              busy
);

  localparam logic [2:0] ISSUE             = 3'd0;
  localparam logic [2:0] RD_INDIRECT_SHIFT = 3'd1;
  localparam logic [2:0] WITH_SHIFT        = 3'd2;
  localparam logic [2:0] TRANSFER          = 3'd3;
  localparam logic [2:0] BASE_WRITEBACK    = 3'd4;
  localparam logic [2:0] EXCEPTION         = 3'd5;
  localparam logic [2:0] MUL               = 3'd6;

  // The counter only needs to hold MUL_CYCLES-2; keep at least one bit when MUL is never used.
  localparam int              MUL_W    = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam logic [MUL_W-1:0] MUL_LOAD = MUL_W'((MUL_CYCLES > 2) ? (MUL_CYCLES - 2) : 0);
  localparam logic             MUL_EN   = (MUL_CYCLES > 1) ? 1'b1 : 1'b0;

  logic [XFER_W-1:0] beats_r;
  logic [MUL_W-1:0]  mul_cnt_r;
  logic [2:0]        post_issue_s;
  logic              last_s;
  logic              xfer_entry_s;
  logic              mul_entry_s;
  logic [XFER_W-1:0] beats_load_s;

  assign post_issue_s = (mul && MUL_EN) ? MUL : (ldst ? TRANSFER : ISSUE);
  assign last_s       = (cycle == TRANSFER) && (xfer_idx == (beats_r - {{(XFER_W-1){1'b0}}, 1'b1}));
  assign xfer_entry_s = (next_cycle == TRANSFER) && (cycle != TRANSFER);
  assign mul_entry_s  = (next_cycle == MUL) && (cycle != MUL);
  assign beats_load_s = (xfer_count == {XFER_W{1'b0}}) ? {{(XFER_W-1){1'b0}}, 1'b1} : xfer_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle <= ISSUE;
    end else begin
      cycle <= next_cycle;
    end
  end

  // Next-state decode; TRANSFER and MUL deliberately ignore bubble so they run to completion
  always_comb begin
    next_cycle = ISSUE;
    case (cycle)
      ISSUE: begin
        if (bubble)                     next_cycle = ISSUE;
        else if (exception)             next_cycle = EXCEPTION;
        else if (data_snd_shift_by_reg) next_cycle = RD_INDIRECT_SHIFT;
        else if (!trivial_shift)        next_cycle = WITH_SHIFT;
        else                            next_cycle = post_issue_s;
      end
      RD_INDIRECT_SHIFT: begin
        if (bubble)              next_cycle = ISSUE;
        else if (!trivial_shift) next_cycle = WITH_SHIFT;
        else                     next_cycle = post_issue_s;
      end
      WITH_SHIFT: begin
        if (bubble) next_cycle = ISSUE;
        else        next_cycle = post_issue_s;
      end
      MUL: begin
        if (mul_cnt_r != {MUL_W{1'b0}}) next_cycle = MUL;
        else if (ldst)                  next_cycle = TRANSFER;
        else                            next_cycle = ISSUE;
      end
      TRANSFER: begin
        if (mem_ready && mem_error)  next_cycle = EXCEPTION;
        else if (mem_ready && last_s) next_cycle = ldst_writeback ? BASE_WRITEBACK : ISSUE;
        else                          next_cycle = TRANSFER;
      end
      BASE_WRITEBACK, EXCEPTION: begin
        if (bubble) next_cycle = ISSUE;
        else        next_cycle = post_issue_s;
      end
      default: next_cycle = ISSUE;
    endcase
  end

  // Status outputs derived from state
  always_comb begin
    busy      = (next_cycle != ISSUE);
    last_xfer = last_s;
  end

  // Burst length latch and beat index; index is cleared whenever the burst is not continuing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_r  <= {XFER_W{1'b0}};
      xfer_idx <= {XFER_W{1'b0}};
    end else if (xfer_entry_s) begin
      beats_r  <= beats_load_s;
      xfer_idx <= {XFER_W{1'b0}};
    end else if (next_cycle == TRANSFER) begin
      if (mem_ready && !mem_error && !last_s) begin
        xfer_idx <= xfer_idx + {{(XFER_W-1){1'b0}}, 1'b1};
      end else begin
        xfer_idx <= xfer_idx;
      end
    end else begin
      xfer_idx <= {XFER_W{1'b0}};
    end
  end

  // Multiply wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt_r <= {MUL_W{1'b0}};
    end else if (mul_entry_s) begin
      mul_cnt_r <= MUL_LOAD;
    end else if ((cycle == MUL) && (mul_cnt_r != {MUL_W{1'b0}})) begin
      mul_cnt_r <= mul_cnt_r - {{(MUL_W-1){1'b0}}, 1'b1};
    end else begin
      mul_cnt_r <= mul_cnt_r;
    end
  end

endmodule

// File: tb/tb_core_control_cycle_seq.sv
// Directed bench for core_control_cycle_seq: each row drives one cycle of inputs and
// queues the expected outputs; a negedge monitor pops and compares.
module tb_core_control_cycle_seq;

  localparam logic [2:0] S_ISS = 3'd0, S_RIS = 3'd1, S_WS = 3'd2, S_XF = 3'd3,
                         S_BW = 3'd4, S_EXC = 3'd5, S_MUL = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bubble, exception, data_snd_shift_by_reg, trivial_shift, mul, ldst;
  logic [4:0] xfer_count;
  logic       ldst_writeback, mem_ready, mem_error;
  logic [2:0] cycle, next_cycle;
  logic [4:0] xfer_idx;
  logic       last_xfer, busy;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int         id;
    logic [2:0] cyc;
    logic [2:0] nxt;
    logic [4:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];

  core_control_cycle_seq #(.XFER_W(5), .MUL_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .bubble(bubble), .exception(exception),
    .data_snd_shift_by_reg(data_snd_shift_by_reg), .trivial_shift(trivial_shift),
    .mul(mul), .ldst(ldst), .xfer_count(xfer_count), .ldst_writeback(ldst_writeback),
    .mem_ready(mem_ready), .mem_error(mem_error), .cycle(cycle), .next_cycle(next_cycle),
    .xfer_idx(xfer_idx), .last_xfer(last_xfer), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, id, act, expv);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cycle",      e.id, 32'(cycle),      32'(e.cyc));
      chk("next_cycle", e.id, 32'(next_cycle), 32'(e.nxt));
      chk("xfer_idx",   e.id, 32'(xfer_idx),   32'(e.idx));
      chk("last_xfer",  e.id, 32'(last_xfer),  32'(e.last));
      chk("busy",       e.id, 32'(busy),       32'(e.nxt != S_ISS));
    end
  end

  task automatic apply(input int id, input logic bub, exc, sbr, triv, ml, ls,
                       input logic [4:0] cnt, input logic wb, rdy, err,
                       input logic [2:0] ecyc, enxt, input logic [4:0] eidx, input logic elast);
    exp_t e;
    bubble = bub; exception = exc; data_snd_shift_by_reg = sbr; trivial_shift = triv;
    mul = ml; ldst = ls; xfer_count = cnt; ldst_writeback = wb; mem_ready = rdy; mem_error = err;
    e.id = id; e.cyc = ecyc; e.nxt = enxt; e.idx = eidx; e.last = elast;
    exp_q.push_back(e);
  endtask

  task automatic step(input int id, input logic bub, exc, sbr, triv, ml, ls,
                      input logic [4:0] cnt, input logic wb, rdy, err,
                      input logic [2:0] ecyc, enxt, input logic [4:0] eidx, input logic elast);
    apply(id, bub, exc, sbr, triv, ml, ls, cnt, wb, rdy, err, ecyc, enxt, eidx, elast);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int id);
    step(id, 0,0,0,1,0,0, 5'd0, 0,0,0, S_ISS, S_ISS, 5'd0, 1'b0);
  endtask

  initial begin
    bubble = 1'b0; exception = 1'b0; data_snd_shift_by_reg = 1'b0; trivial_shift = 1'b1;
    mul = 1'b0; ldst = 1'b0; xfer_count = 5'd0; ldst_writeback = 1'b0;
    mem_ready = 1'b0; mem_error = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    idle(1);
    // 4-beat burst, always ready, no writeback
    step(10, 0,0,0,1,0,1, 5'd4, 0,1,0, S_ISS, S_XF,  5'd0, 1'b0);
    step(11, 0,0,0,1,0,1, 5'd4, 0,1,0, S_XF,  S_XF,  5'd0, 1'b0);
    step(12, 0,0,0,1,0,1, 5'd4, 0,1,0, S_XF,  S_XF,  5'd1, 1'b0);
    step(13, 0,0,0,1,0,1, 5'd4, 0,1,0, S_XF,  S_XF,  5'd2, 1'b0);
    step(14, 0,0,0,1,0,1, 5'd4, 0,1,0, S_XF,  S_ISS, 5'd3, 1'b1);
    idle(15);
    // 2-beat burst with three stall cycles on beat 0, then base writeback
    step(20, 0,0,0,1,0,1, 5'd2, 1,0,0, S_ISS, S_XF,  5'd0, 1'b0);
    step(21, 0,0,0,1,0,1, 5'd2, 1,0,0, S_XF,  S_XF,  5'd0, 1'b0);
    step(22, 0,0,0,1,0,1, 5'd2, 1,0,0, S_XF,  S_XF,  5'd0, 1'b0);
    step(23, 0,0,0,1,0,1, 5'd2, 1,0,0, S_XF,  S_XF,  5'd0, 1'b0);
    step(24, 0,0,0,1,0,1, 5'd2, 1,1,0, S_XF,  S_XF,  5'd0, 1'b0);
    step(25, 0,0,0,1,0,1, 5'd2, 1,1,0, S_XF,  S_BW,  5'd1, 1'b1);
    step(26, 0,0,0,1,0,0, 5'd0, 0,0,0, S_BW,  S_ISS, 5'd0, 1'b0);
    idle(27);
    // Register-shifted multiply: issue + two MUL cycles
    step(30, 0,0,1,0,1,0, 5'd0, 0,0,0, S_ISS, S_RIS, 5'd0, 1'b0);
    step(31, 0,0,1,0,1,0, 5'd0, 0,0,0, S_RIS, S_WS,  5'd0, 1'b0);
    step(32, 0,0,1,0,1,0, 5'd0, 0,0,0, S_WS,  S_MUL, 5'd0, 1'b0);
    step(33, 0,0,1,0,1,0, 5'd0, 0,0,0, S_MUL, S_MUL, 5'd0, 1'b0);
    step(34, 0,0,1,0,1,0, 5'd0, 0,0,0, S_MUL, S_ISS, 5'd0, 1'b0);
    idle(35);
    // Multiply followed by a single-beat transfer; bubble ignored in MUL
    step(36, 0,0,0,1,1,1, 5'd1, 0,1,0, S_ISS, S_MUL, 5'd0, 1'b0);
    step(37, 1,0,0,1,1,1, 5'd1, 0,1,0, S_MUL, S_MUL, 5'd0, 1'b0);
    step(38, 1,0,0,1,1,1, 5'd1, 0,1,0, S_MUL, S_XF,  5'd0, 1'b0);
    step(39, 0,0,0,1,1,1, 5'd1, 0,1,0, S_XF,  S_ISS, 5'd0, 1'b1);
    idle(40);
    // Abort on beat 1 of 3; bubble on beat 0 has no effect
    step(41, 0,0,0,1,0,1, 5'd3, 0,1,0, S_ISS, S_XF,  5'd0, 1'b0);
    step(42, 1,0,0,1,0,1, 5'd3, 0,1,0, S_XF,  S_XF,  5'd0, 1'b0);
    step(43, 0,0,0,1,0,1, 5'd3, 0,1,1, S_XF,  S_EXC, 5'd1, 1'b0);
    step(44, 0,0,0,1,0,0, 5'd0, 0,0,0, S_EXC, S_ISS, 5'd0, 1'b0);
    idle(45);
    // xfer_count=0 means one beat
    step(50, 0,0,0,1,0,1, 5'd0, 0,1,0, S_ISS, S_XF,  5'd0, 1'b0);
    step(51, 0,0,0,1,0,1, 5'd0, 0,1,0, S_XF,  S_ISS, 5'd0, 1'b1);
    idle(52);
    // Asynchronous reset in the middle of a burst at beat 2
    step(53, 0,0,0,1,0,1, 5'd4, 0,1,0, S_ISS, S_XF,  5'd0, 1'b0);
    step(54, 0,0,0,1,0,1, 5'd4, 0,1,0, S_XF,  S_XF,  5'd0, 1'b0);
    step(55, 0,0,0,1,0,1, 5'd4, 0,1,0, S_XF,  S_XF,  5'd1, 1'b0);
    apply(56, 0,0,0,1,0,1, 5'd4, 0,1,0, S_XF,  S_XF,  5'd2, 1'b0);
    @(negedge clk); #1 rst_n = 1'b0; #1;
    chk("async_rst_cycle", 56, 32'(cycle),    32'(S_ISS));
    chk("async_rst_idx",   56, 32'(xfer_idx), 32'd0);
    chk("async_rst_busy",  56, 32'(busy),     32'd1);
    apply(57, 0,0,0,1,0,1, 5'd4, 0,1,0, S_ISS, S_XF,  5'd0, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1; ldst = 1'b0; mem_ready = 1'b0; xfer_count = 5'd0;
    @(posedge clk); #1;
    idle(58);
    // Exception with bubble is squashed; exception alone takes one EXCEPTION cycle
    step(60, 1,1,0,1,0,0, 5'd0, 0,0,0, S_ISS, S_ISS, 5'd0, 1'b0);
    step(61, 0,1,0,1,0,0, 5'd0, 0,0,0, S_ISS, S_EXC, 5'd0, 1'b0);
    step(62, 0,1,0,1,0,0, 5'd0, 0,0,0, S_EXC, S_ISS, 5'd0, 1'b0);
    idle(63);
    // Bubble squashes RD_INDIRECT_SHIFT; mem_error outside TRANSFER is ignored
    step(64, 0,0,1,0,0,0, 5'd0, 0,0,0, S_ISS, S_RIS, 5'd0, 1'b0);
    step(65, 1,0,1,0,0,0, 5'd0, 0,0,0, S_RIS, S_ISS, 5'd0, 1'b0);
    step(66, 0,0,0,1,0,0, 5'd0, 0,1,1, S_ISS, S_ISS, 5'd0, 1'b0);
    idle(67);

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
